// File: rtl/cpe_pkg.sv
// Shared constants and types for the CPE instruction-fetch front end.
package cpe_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;
  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [ILEN-1:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/cpe_fetch_unit_if.sv
// Instruction-memory, redirect and decode handshake bundle of the fetch unit.
interface cpe_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req_w_o_h;
  logic [XLEN-1:0] imem_addr_w_o;
  logic            imem_gnt_w_i_h;
  logic            imem_rvalid_w_i_h;
  logic [31:0]     imem_rdata_w_i;
  logic            redir_w_i_h;
  logic [XLEN-1:0] redir_pc_w_i;
  logic            instr_valid_w_o_h;
  logic [31:0]     instr_w_o;
  logic [XLEN-1:0] pc_w_o;
  logic            instr_ready_w_i_h;

  modport master (
    output imem_req_w_o_h, imem_addr_w_o,
    output instr_valid_w_o_h, instr_w_o, pc_w_o,
    input  imem_gnt_w_i_h, imem_rvalid_w_i_h,
    input  imem_rdata_w_i, redir_w_i_h,
    input  redir_pc_w_i, instr_ready_w_i_h
  );

  modport slave (
    input  imem_req_w_o_h, imem_addr_w_o,
    input  instr_valid_w_o_h, instr_w_o, pc_w_o,
    output imem_gnt_w_i_h, imem_rvalid_w_i_h,
    output imem_rdata_w_i, redir_w_i_h,
    output redir_pc_w_i, instr_ready_w_i_h
  );

endinterface

// File: rtl/cpe_sync_fifo.sv
// Synchronous FIFO with flush and occupancy output; DEPTH is a power of 2.
module cpe_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;

  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push)
        r_wp <= r_wp + AW'(1);
      if (i_pop)
        r_rp <= r_rp + AW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/cpe_fetch_unit.sv
// RV32I fetch front end: credit-limited imem requests, prefetch queue, redirect flush.
// CPE_FETCH_PERF_EN adds saturating stall/flush counters.
module cpe_fetch_unit
  import cpe_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_w_i,
  input  logic              res_w_i_l,
  cpe_fetch_unit_if.master  bus
`ifdef CPE_FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cnt_w_o,
  output logic [31:0]       flush_cnt_w_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_resp_pc;
  logic [CW-1:0]        r_infl;
  logic [CW-1:0]        r_disc;
  logic                 r_run;

  logic [CW-1:0]        w_occ;
  logic                 w_empty;
  logic [XLEN+ILEN-1:0] w_head;
  logic [XLEN-1:0]      w_tgt;
  logic                 w_redir;
  logic                 w_rvalid;
  logic                 w_credit;
  logic                 w_req;
  logic                 w_issue;
  logic                 w_drop;
  logic                 w_push;
  logic                 w_pop;

  assign w_redir  = bus.redir_w_i_h;
  assign w_rvalid = bus.imem_rvalid_w_i_h;
  assign w_tgt    = bus.redir_pc_w_i & ~XLEN'(3);

  // Queued plus outstanding fetches never exceed the queue size.
  assign w_credit = ({1'b0, w_occ} + {1'b0, r_infl}) < (CW+1)'(DEPTH);
  assign w_req    = r_run & w_credit & ~w_redir;
  assign w_issue  = w_req & bus.imem_gnt_w_i_h;
  assign w_drop   = w_rvalid & (w_redir | (r_disc != '0));
  assign w_push   = w_rvalid & ~w_drop;
  assign w_pop    = ~w_empty & bus.instr_ready_w_i_h & ~w_redir;

  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
      r_infl    <= '0;
      r_disc    <= '0;
      r_run     <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_infl <= r_infl + CW'(w_issue) - CW'(w_rvalid);
      if (w_redir) begin
        r_pc      <= w_tgt;
        r_resp_pc <= w_tgt;
        r_disc    <= r_infl - CW'(w_rvalid);
      end else begin
        if (w_issue)
          r_pc <= r_pc + XLEN'(PC_STEP);
        if (w_push)
          r_resp_pc <= r_resp_pc + XLEN'(PC_STEP);
        if (w_rvalid && r_disc != '0)
          r_disc <= r_disc - CW'(1);
      end
    end
  end

  cpe_sync_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk_w_i),
    .rst_n   (res_w_i_l),
    .i_flush (w_redir),
    .i_push  (w_push),
    .i_data  ({r_resp_pc, bus.imem_rdata_w_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_occ),
    .o_empty (w_empty)
  );

  assign bus.imem_req_w_o_h    = w_req;
  assign bus.imem_addr_w_o     = r_pc;
  assign bus.instr_valid_w_o_h = ~w_empty;
  assign bus.instr_w_o         = w_empty ? NOP_INSTR : w_head[ILEN-1:0];
  assign bus.pc_w_o            = w_empty ? '0 : w_head[XLEN+ILEN-1:ILEN];

`ifdef CPE_FETCH_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_empty && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redir && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_w_o = r_stall_cnt;
  assign flush_cnt_w_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_cpe_fetch_unit.sv
// Directed bench for cpe_fetch_unit with an in-order, fixed-latency imem model.
module tb_cpe_fetch_unit;

  logic clk;
  logic res_n;

  cpe_fetch_unit_if #(.XLEN(32)) bus ();

`ifdef CPE_FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  cpe_fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk_w_i   (clk),
    .res_w_i_l (res_n),
    .bus       (bus)
`ifdef CPE_FETCH_PERF_EN
    ,
    .stall_cnt_w_o (stall_cnt),
    .flush_cnt_w_o (flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_err;
  int cyc;
  int lat;

  logic [31:0] q_addr [$];
  int          q_due  [$];
  logic [31:0] iss    [$];
  logic [31:0] pop_pc [$];
  logic [31:0] pop_in [$];
  int          pop_cy [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pc_at(input int i);
    return (pop_pc.size() > i) ? pop_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] in_at(input int i);
    return (pop_in.size() > i) ? pop_in[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int cy_at(input int i);
    return (pop_cy.size() > i) ? pop_cy[i] : -100;
  endfunction

  task automatic step();
    logic [31:0] a;
    #1;
    if (bus.imem_req_w_o_h && bus.imem_gnt_w_i_h) begin
      a = bus.imem_addr_w_o;
      q_addr.push_back(a);
      q_due.push_back(cyc + lat);
      iss.push_back(a);
    end
    if (bus.instr_valid_w_o_h && bus.instr_ready_w_i_h && !bus.redir_w_i_h) begin
      pop_pc.push_back(bus.pc_w_o);
      pop_in.push_back(bus.instr_w_o);
      pop_cy.push_back(cyc);
    end
    if (bus.imem_rvalid_w_i_h) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      bus.imem_rvalid_w_i_h = 1'b1;
      bus.imem_rdata_w_i    = q_addr[0] + 32'h0100_0000;
    end else begin
      bus.imem_rvalid_w_i_h = 1'b0;
      bus.imem_rdata_w_i    = 32'h0;
    end
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    bus.imem_gnt_w_i_h    = 1'b0;
    bus.imem_rvalid_w_i_h = 1'b0;
    bus.imem_rdata_w_i    = 32'h0;
    bus.redir_w_i_h       = 1'b0;
    bus.redir_pc_w_i      = 32'h0;
    bus.instr_ready_w_i_h = 1'b0;
    q_addr.delete();
    q_due.delete();
    iss.delete();
    pop_pc.delete();
    pop_in.delete();
    pop_cy.delete();
    repeat (2) step();
    res_n = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    lat   = 1;
    res_n = 1'b0;
    do_reset();
    res_n = 1'b0;
    #1;
    chk("rst_req",   64'(bus.imem_req_w_o_h),    64'd0);
    chk("rst_addr",  64'(bus.imem_addr_w_o),     64'h0);
    chk("rst_valid", 64'(bus.instr_valid_w_o_h), 64'd0);
    chk("rst_instr", 64'(bus.instr_w_o),         64'h13);
    chk("rst_pc",    64'(bus.pc_w_o),            64'h0);

    // 1: streaming, 1-cycle latency
    do_reset();
    lat = 1;
    bus.imem_gnt_w_i_h    = 1'b1;
    bus.instr_ready_w_i_h = 1'b1;
    repeat (14) step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pc%0d", i), 64'(pc_at(i)), 64'(4 * i));
      chk($sformatf("t1_in%0d", i), 64'(in_at(i)),
          64'(32'h0100_0000 + 32'(4 * i)));
    end
    for (int i = 1; i < 6; i++)
      chk($sformatf("t1_gap%0d", i), 64'(cy_at(i) - cy_at(i - 1)), 64'd1);

    // 2: credit stall with decode blocked
    do_reset();
    lat = 1;
    bus.imem_gnt_w_i_h = 1'b1;
    repeat (10) step();
    chk("t2_iss4", 64'(iss.size()), 64'd4);
    #1;
    chk("t2_req_lo", 64'(bus.imem_req_w_o_h), 64'd0);
    bus.instr_ready_w_i_h = 1'b1;
    step();
    bus.instr_ready_w_i_h = 1'b0;
    repeat (6) step();
    chk("t2_iss5", 64'(iss.size()), 64'd5);
    chk("t2_pop1", 64'(pop_pc.size()), 64'd1);

    // 3: redirect with two responses in flight
    do_reset();
    lat = 3;
    bus.instr_ready_w_i_h = 1'b1;
    for (int k = 0; k < 20 && iss.size() < 2; k++) begin
      bus.imem_gnt_w_i_h = 1'b1;
      step();
    end
    bus.imem_gnt_w_i_h = 1'b0;
    chk("t3_iss2", 64'(iss.size()), 64'd2);
    bus.redir_w_i_h  = 1'b1;
    bus.redir_pc_w_i = 32'h100;
    step();
    bus.redir_w_i_h    = 1'b0;
    bus.imem_gnt_w_i_h = 1'b1;
    repeat (15) step();
    chk("t3_pc0", 64'(pc_at(0)), 64'h100);
    chk("t3_in0", 64'(in_at(0)), 64'h0100_0100);
    chk("t3_pc1", 64'(pc_at(1)), 64'h104);

    // 4: unaligned target, response coincides with redirect
    do_reset();
    lat = 2;
    bus.instr_ready_w_i_h = 1'b1;
    for (int k = 0; k < 20 && iss.size() < 1; k++) begin
      bus.imem_gnt_w_i_h = 1'b1;
      step();
    end
    bus.imem_gnt_w_i_h = 1'b0;
    step();
    bus.redir_w_i_h  = 1'b1;
    bus.redir_pc_w_i = 32'h203;
    #1;
    chk("t4_rv_now", 64'(bus.imem_rvalid_w_i_h), 64'd1);
    chk("t4_req_lo", 64'(bus.imem_req_w_o_h), 64'd0);
    step();
    bus.redir_w_i_h = 1'b0;
    #1;
    chk("t4_addr", 64'(bus.imem_addr_w_o), 64'h200);
    chk("t4_req_hi", 64'(bus.imem_req_w_o_h), 64'd1);
    chk("t4_valid_lo", 64'(bus.instr_valid_w_o_h), 64'd0);
    bus.imem_gnt_w_i_h = 1'b1;
    repeat (10) step();
    chk("t4_pc0", 64'(pc_at(0)), 64'h200);
    chk("t4_in0", 64'(in_at(0)), 64'h0100_0200);

    // 5: PC wraps at the top of the address space
    do_reset();
    lat = 1;
    bus.imem_gnt_w_i_h    = 1'b1;
    bus.instr_ready_w_i_h = 1'b1;
    step();
    bus.redir_w_i_h  = 1'b1;
    bus.redir_pc_w_i = 32'hFFFF_FFFC;
    step();
    bus.redir_w_i_h = 1'b0;
    repeat (8) step();
    chk("t5_pc0", 64'(pc_at(0)), 64'hFFFF_FFFC);
    chk("t5_pc1", 64'(pc_at(1)), 64'h0);
    chk("t5_in1", 64'(in_at(1)), 64'h0100_0000);

    // 6: asynchronous reset mid-operation
    do_reset();
    lat = 3;
    bus.imem_gnt_w_i_h = 1'b1;
    repeat (6) step();
    #1;
    chk("t6_pre_valid", 64'(bus.instr_valid_w_o_h), 64'd1);
    res_n = 1'b0;
    #1;
    chk("t6_req0",   64'(bus.imem_req_w_o_h),    64'd0);
    chk("t6_valid0", 64'(bus.instr_valid_w_o_h), 64'd0);
    chk("t6_addr0",  64'(bus.imem_addr_w_o),     64'h0);
    do_reset();
    lat = 1;
    bus.imem_gnt_w_i_h    = 1'b1;
    bus.instr_ready_w_i_h = 1'b1;
    repeat (6) step();
    chk("t6_iss0", 64'((iss.size() > 0) ? iss[0] : 32'hDEAD_BEEF), 64'h0);
    chk("t6_pc0",  64'(pc_at(0)), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
